// File: rtl/jt12_pcm_multirate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt12_pcm_multirate_pkg
// Purpose  : Shared constants and rate helpers for the PCM multirate upsampler
// Revision : 1.0 - initial release
// ============================================================================
package jt12_pcm_multirate_pkg;

  // Largest supported log2 upsample factor
  localparam int c_maxlog_limit = 4;
  // Width of the rate fields (rate_force, rate_cur)
  localparam int c_rate_w = 3;
  // Widest gap counter the helpers must accept (c_maxlog_limit + 1 bits)
  localparam int c_cnt_w_max = c_maxlog_limit + 1;

  // Clamp a log2 rate to the configured maximum
  function automatic logic [c_rate_w-1:0] rate_clip(input logic [c_rate_w-1:0] r,
                                                    input int maxlog);
    if (int'(r) > maxlog) begin
      return c_rate_w'(maxlog);
    end
    return r;
  endfunction

  // floor(log2(x)) clamped to maxlog; x=0 and x=1 both give 0
  function automatic logic [c_rate_w-1:0] log2_clip(input logic [c_cnt_w_max-1:0] x,
                                                    input int maxlog);
    logic [c_rate_w-1:0] msb;
    msb = '0;
    for (int i = 1; i < c_cnt_w_max; i++) begin
      if (x[i]) begin
        msb = c_rate_w'(i);
      end
    end
    return rate_clip(msb, maxlog);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_pcm_interp_stage.sv
`default_nettype none
// ============================================================================
// Module   : jt12_pcm_interp_stage
// Purpose  : One 2x linear-interpolation stage: emits the midpoint between the
//            previous and new input on cen_in, then the new input itself on
//            the following cen_out.
// Revision : 1.0 - initial release
// ============================================================================
module jt12_pcm_interp_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen_in,
  input  logic         cen_out,
  input  logic [W-1:0] snd_in,
  output logic [W-1:0] snd_out
);

  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] out_q, out_d;
  logic [W:0]   w_sum;

  // Midpoint at W+1 bits so the sum never overflows; dropping bit 0 is the
  // arithmetic shift, and the result always fits back into W bits.
  always_comb begin
    w_sum = {cur_q[W-1], cur_q} + {snd_in[W-1], snd_in};
    cur_d = cur_q;
    out_d = out_q;
    if (cen_in) begin
      out_d = w_sum[W:1];
      cur_d = snd_in;
    end else if (cen_out) begin
      out_d = cur_q;
    end
  end

  // Stage state register
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      out_q <= '0;
    end else begin
      cur_q <= cur_d;
      out_q <= out_d;
    end
  end

  assign snd_out = out_q;

endmodule
`default_nettype wire

// File: rtl/jt12_pcm_multirate.sv
`default_nettype none
// ============================================================================
// Module   : jt12_pcm_multirate
// Purpose  : Upsamples CPU-written PCM to the FM output sample rate with a
//            cascade of 2x linear interpolators; the depth is either forced
//            or derived from the measured write interval.
// Revision : 1.0 - initial release
// ============================================================================
module jt12_pcm_multirate #(
  parameter int W      = 9,
  parameter int MAXLOG = 3   // legal range 1..c_maxlog_limit
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         zero,
  input  logic [W-1:0] pcm,
  input  logic         pcm_wr,
  input  logic         auto_en,
  input  logic [2:0]   rate_force,
  output logic [W-1:0] pcm_resampled,
  output logic [2:0]   rate_cur
);
  import jt12_pcm_multirate_pkg::*;

  localparam int                 c_cnt_w   = MAXLOG + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic              zero_prev_q, zero_prev_d;
  logic [W-1:0]      hold_q, hold_d;
  logic [MAXLOG-1:0] phase_q, phase_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]        meas_q, meas_d;
  logic [2:0]        rate_q, rate_d;
  logic [W-1:0]      byp_q, byp_d;

  logic              w_tick;
  logic              w_wr;
  logic [2:0]        w_target;
  logic [MAXLOG+1:1] w_cen;
  logic [W-1:0]      w_stage_in  [1:MAXLOG];
  logic [W-1:0]      w_stage_out [1:MAXLOG];

  assign w_tick   = zero & ~zero_prev_q;
  assign w_wr     = pcm_wr & clk_en;
  assign w_target = auto_en ? meas_q : rate_clip(rate_force, MAXLOG);

  // Stage k emits every 2^(k-1) ticks; w_cen[MAXLOG+1] marks a full period
  for (genvar k = 1; k <= MAXLOG + 1; k++) begin : g_cen
    localparam logic [MAXLOG-1:0] c_mask = MAXLOG'((1 << (k - 1)) - 1);
    assign w_cen[k] = w_tick & ~|(phase_q & c_mask);
  end

  // Interpolator chain; the stage numbered rate_cur is fed from the hold register
  for (genvar k = 1; k <= MAXLOG; k++) begin : g_stage
    if (k == MAXLOG) begin : g_outer
      assign w_stage_in[k] = hold_q;
    end else begin : g_inner
      assign w_stage_in[k] = (rate_q == 3'(k)) ? hold_q : w_stage_out[k+1];
    end

    jt12_pcm_interp_stage #(
      .W(W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .cen_in (w_cen[k+1]),
      .cen_out(w_cen[k]),
      .snd_in (w_stage_in[k]),
      .snd_out(w_stage_out[k])
    );
  end

  // Write capture, gap measurement, phase tracking and rate selection.
  // meas resets to 1 so that auto mode starts at the same rate as rate_cur.
  always_comb begin
    zero_prev_d = zero;
    hold_d      = hold_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    meas_d      = meas_q;
    rate_d      = rate_q;
    byp_d       = byp_q;
    if (w_wr) begin
      hold_d = pcm;
      meas_d = log2_clip(c_cnt_w_max'(cnt_q), MAXLOG);
      cnt_d  = w_tick ? c_cnt_one : '0;
    end else if (w_tick && (cnt_q != c_cnt_max)) begin
      cnt_d = cnt_q + c_cnt_one;
    end
    if (w_tick) begin
      phase_d = phase_q + MAXLOG'(1);
      byp_d   = hold_q;
      // Rate only switches on a period boundary so no interpolation is cut short
      if (phase_q == '0) begin
        rate_d = w_target;
      end
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_prev_q <= 1'b0;
      hold_q      <= '0;
      phase_q     <= '0;
      cnt_q       <= '0;
      meas_q      <= 3'd1;
      rate_q      <= 3'd1;
      byp_q       <= '0;
    end else begin
      zero_prev_q <= zero_prev_d;
      hold_q      <= hold_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      meas_q      <= meas_d;
      rate_q      <= rate_d;
      byp_q       <= byp_d;
    end
  end

  assign pcm_resampled = (rate_q == 3'd0) ? byp_q : w_stage_out[1];
  assign rate_cur      = rate_q;

endmodule
`default_nettype wire
